// File: rtl/press_pattern_gen.sv
// Synthetic push-button generator: holds inc for a short or long press, then forces a release gap.
// Optional macro PRESS_QUEUE_EN adds a one-entry pending request slot served on the done cycle.
module press_pattern_gen #(
    parameter int unsigned SHORT_TICKS = 50,
    parameter int unsigned LONG_TICKS  = 600,
    parameter int unsigned GAP_TICKS   = 20,
    parameter int unsigned CNT_W       = 15
) (
    input  logic clk_10000Hz,
    input  logic rst,
    input  logic req_short,
    input  logic req_long,
    output logic inc,
    output logic busy,
    output logic done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] SHORT_CNT = CNT_W'(SHORT_TICKS);
    localparam logic [CNT_W-1:0] LONG_CNT  = CNT_W'(LONG_TICKS);
    localparam logic [CNT_W-1:0] GAP_CNT   = CNT_W'(GAP_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inc_q, inc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             req_any;
    logic [CNT_W-1:0] req_len;

    assign req_any = req_short | req_long;
    assign req_len = req_long ? LONG_CNT : SHORT_CNT;

`ifdef PRESS_QUEUE_EN
    logic pend_vld_q, pend_vld_d;
    logic pend_long_q, pend_long_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef PRESS_QUEUE_EN
        pend_vld_d  = pend_vld_q;
        pend_long_d = pend_long_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    state_d = ST_PRESS;
                    cnt_d   = req_len;
                end
            end
            ST_PRESS: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_CNT;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
`ifdef PRESS_QUEUE_EN
                    // Done cycle: a stored request beats a fresh one arriving now
                    if (pend_vld_q) begin
                        state_d    = ST_PRESS;
                        cnt_d      = pend_long_q ? LONG_CNT : SHORT_CNT;
                        pend_vld_d = 1'b0;
                    end else if (req_any) begin
                        state_d = ST_PRESS;
                        cnt_d   = req_len;
                    end
`endif
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

`ifdef PRESS_QUEUE_EN
        if ((state_q != ST_IDLE) && !((state_q == ST_GAP) && (cnt_q == CNT_ONE))
            && req_any && !pend_vld_q) begin
            pend_vld_d  = 1'b1;
            pend_long_d = req_long;
        end
`endif

        // Outputs are registered copies of what the next state implies
        inc_d  = (state_d == ST_PRESS);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_GAP) && (cnt_d == CNT_ONE);
    end

    always_ff @(posedge clk_10000Hz) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            inc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            inc_q   <= inc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef PRESS_QUEUE_EN
    always_ff @(posedge clk_10000Hz) begin
        if (rst) begin
            pend_vld_q  <= 1'b0;
            pend_long_q <= 1'b0;
        end else begin
            pend_vld_q  <= pend_vld_d;
            pend_long_q <= pend_long_d;
        end
    end
`endif

    assign inc  = inc_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_press_pattern_gen.sv
// Bench for press_pattern_gen: timestamp-based press model checked every cycle, plus literal pins.
// Follows PRESS_QUEUE_EN the same way the design does.
module tb_press_pattern_gen;

    localparam int SHORT = 50;
    localparam int LONG  = 600;
    localparam int GAP   = 20;
    localparam int LOGN  = 2048;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_short = 1'b0;
    logic req_long  = 1'b0;
    logic inc, busy, done;

    press_pattern_gen #(
        .SHORT_TICKS(SHORT),
        .LONG_TICKS (LONG),
        .GAP_TICKS  (GAP),
        .CNT_W      (15)
    ) dut (
        .clk_10000Hz(clk),
        .rst        (rst),
        .req_short  (req_short),
        .req_long   (req_long),
        .inc        (inc),
        .busy       (busy),
        .done       (done)
    );

    always #50 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int t        = 0;
    bit chk_en   = 1'b0;

    // Model: one active press described by start/end/done cycle stamps
    bit m_act = 1'b0;
    int m_ps = 0, m_pe = 0, m_dc = 0;
    bit m_pend = 1'b0, m_pend_long = 1'b0;
    int acc_s = 0, acc_l = 0;

    int run = 0, obs_s = 0, obs_l = 0, obs_bad = 0;

    bit inc_log  [0:LOGN-1];
    bit busy_log [0:LOGN-1];
    bit done_log [0:LOGN-1];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    function automatic int cnt_inc(input int a, input int b);
        int s = 0;
        for (int i = a; i <= b; i++) s += int'(inc_log[i]);
        return s;
    endfunction

    function automatic int cnt_done(input int a, input int b);
        int s = 0;
        for (int i = a; i <= b; i++) s += int'(done_log[i]);
        return s;
    endfunction

    task automatic m_start(input int c, input bit is_long);
        int len;
        len   = is_long ? LONG : SHORT;
        m_act = 1'b1;
        m_ps  = c + 1;
        m_pe  = c + len;
        m_dc  = c + len + GAP;
        if (is_long) acc_l++;
        else acc_s++;
    endtask

    always @(negedge clk) begin
        logic [2:0] exp_v;
        exp_v[2] = m_act && (t >= m_ps) && (t <= m_pe);
        exp_v[1] = m_act && (t >= m_ps) && (t <= m_dc);
        exp_v[0] = m_act && (t == m_dc);
        if (chk_en)
            check($sformatf("inc_busy_done@%0d", t), int'({inc, busy, done}), int'(exp_v));
        if (t >= 0 && t < LOGN) begin
            inc_log[t]  = inc;
            busy_log[t] = busy;
            done_log[t] = done;
        end
        if (inc) run++;
        else if (run > 0) begin
            if (run == SHORT) obs_s++;
            else if (run == LONG) obs_l++;
            else obs_bad++;
            run = 0;
        end
        if (rst) begin
            m_act  = 1'b0;
            m_pend = 1'b0;
        end else if (!m_act || t > m_dc) begin
            if (req_short || req_long) m_start(t, req_long);
        end else if (t == m_dc) begin
`ifdef PRESS_QUEUE_EN
            if (m_pend) begin
                m_start(t, m_pend_long);
                m_pend = 1'b0;
            end else if (req_short || req_long) begin
                m_start(t, req_long);
            end
`endif
        end else begin
`ifdef PRESS_QUEUE_EN
            if ((req_short || req_long) && !m_pend) begin
                m_pend      = 1'b1;
                m_pend_long = req_long;
            end
`endif
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic run_to(input int c);
        while (t < c) next_cycle();
    endtask

    task automatic pulse(input int c, input bit s, input bit l);
        run_to(c);
        req_short = s;
        req_long  = l;
        next_cycle();
        req_short = 1'b0;
        req_long  = 1'b0;
    endtask

    task automatic start_test(input bit hold_long);
        chk_en    = 1'b0;
        rst       = 1'b1;
        req_long  = hold_long;
        req_short = 1'b0;
        t         = 0;
        next_cycle();
        chk_en = 1'b1;
        next_cycle();
        rst      = 1'b0;
        req_long = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;

        // Reset with req_long held: nothing may start
        start_test(1'b1);
        run_to(12);
        check("t1_inc1", int'(inc_log[1]), 0);
        check("t1_busy1", int'(busy_log[1]), 0);
        check("t1_done1", int'(done_log[1]), 0);
        check("t1_busy3", int'(busy_log[3]), 0);

        // Short press at 10
        start_test(1'b0);
        pulse(10, 1'b1, 1'b0);
        run_to(90);
        check("t2_inc10", int'(inc_log[10]), 0);
        check("t2_inc11", int'(inc_log[11]), 1);
        check("t2_inc60", int'(inc_log[60]), 1);
        check("t2_inc61", int'(inc_log[61]), 0);
        check("t2_busy80", int'(busy_log[80]), 1);
        check("t2_busy81", int'(busy_log[81]), 0);
        check("t2_done79", int'(done_log[79]), 0);
        check("t2_done80", int'(done_log[80]), 1);
        check("t2_inc_count", cnt_inc(0, 89), SHORT);
        check("t2_done_count", cnt_done(0, 89), 1);

        // Both requests together: long wins
        start_test(1'b0);
        pulse(10, 1'b1, 1'b1);
        run_to(650);
        check("t3_inc610", int'(inc_log[610]), 1);
        check("t3_inc611", int'(inc_log[611]), 0);
        check("t3_done630", int'(done_log[630]), 1);
        check("t3_inc_count", cnt_inc(0, 649), LONG);

        // Request during a long press
        start_test(1'b0);
        pulse(10, 1'b0, 1'b1);
        pulse(100, 1'b1, 1'b0);
        run_to(720);
`ifdef PRESS_QUEUE_EN
        check("t4_inc631", int'(inc_log[631]), 1);
        check("t4_inc680", int'(inc_log[680]), 1);
        check("t4_inc681", int'(inc_log[681]), 0);
        check("t4_done700", int'(done_log[700]), 1);
        check("t4_done_count", cnt_done(0, 719), 2);
`else
        check("t4_inc631", int'(inc_log[631]), 0);
        check("t4_busy631", int'(busy_log[631]), 0);
        check("t4_inc_count", cnt_inc(0, 719), LONG);
        check("t4_done_count", cnt_done(0, 719), 1);
`endif

        // Reset mid-press, then a fresh short press
        start_test(1'b0);
        pulse(10, 1'b0, 1'b1);
        run_to(200);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        pulse(205, 1'b1, 1'b0);
        run_to(300);
        check("t5_inc200", int'(inc_log[200]), 1);
        check("t5_inc201", int'(inc_log[201]), 0);
        check("t5_busy201", int'(busy_log[201]), 0);
        check("t5_inc206", int'(inc_log[206]), 1);
        check("t5_inc255", int'(inc_log[255]), 1);
        check("t5_inc256", int'(inc_log[256]), 0);
        check("t5_no_early_done", cnt_done(0, 274), 0);
        check("t5_done275", int'(done_log[275]), 1);

        // Requests while busy and on the done cycle itself
        start_test(1'b0);
        pulse(10, 1'b1, 1'b0);
        pulse(50, 1'b0, 1'b1);
        pulse(80, 1'b1, 1'b0);
        run_to(720);
`ifdef PRESS_QUEUE_EN
        check("t7_inc81", int'(inc_log[81]), 1);
        check("t7_inc680", int'(inc_log[680]), 1);
        check("t7_inc681", int'(inc_log[681]), 0);
        check("t7_done700", int'(done_log[700]), 1);
`else
        check("t7_busy81", int'(busy_log[81]), 0);
        check("t7_inc_count", cnt_inc(0, 719), SHORT);
`endif

        // Random request train: every accepted press appears with the right width
        start_test(1'b0);
        acc_s = 0; acc_l = 0;
        run = 0; obs_s = 0; obs_l = 0; obs_bad = 0;
        for (int i = 0; i < 20; i++) begin
            int kind;
            kind = int'($urandom_range(2, 0));
            pulse(t + int'($urandom_range(700, 1)), kind == 0, kind != 0);
        end
        run_to(t + 1400);
        check("t6_short_presses", obs_s, acc_s);
        check("t6_long_presses", obs_l, acc_l);
        check("t6_bad_widths", obs_bad, 0);
        check("t6_any_accepted", int'((acc_s + acc_l) > 0), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
